// File: rtl/sc_frog_event_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module   : sc_frog_event_ctrl_pkg
// Purpose  : Shared definitions for the frog event controller: controller state
//            encodings, row-register shift codes, default nest column mask and
//            a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
package sc_frog_event_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_HIT      = 3'd2,
      ST_WIN      = 3'd3,
      ST_GAMEOVER = 3'd4
   } frogState_t;

   localparam logic [1:0] SHIFT_NONE  = 2'b00;
   localparam logic [1:0] SHIFT_LEFT  = 2'b01;
   localparam logic [1:0] SHIFT_RIGHT = 2'b10;

   localparam logic [7:0] NEST_MASK_DEFAULT = 8'b10101010;

   // Smallest width (at least 1) whose range covers 0..value-1.
   function automatic int clog2Min1(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sc_frog_event_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : sc_frog_event_ctrl_if
// Purpose  : Bundles the row read-back inputs, start request and the strobe /
//            status outputs of the frog event controller.
// Ports    : master - drives start/row inputs, observes strobes and status
//            slave  - the controller side
// Revision : 1.0 - initial release
//==============================================================================
interface sc_frog_event_ctrl_if #(
   parameter int DATAWIDTH   = 8,
   parameter int SCORE_WIDTH = 4
) ();

   logic                   start_InLow;
   logic [DATAWIDTH-1:0]   frog_row_InBUS;
   logic [DATAWIDTH-1:0]   obstacle_row_InBUS;
   logic                   frog_at_top_In;
   logic [1:0]             shiftselection_Out;
   logic                   collision_OutLow;
   logic                   nest_reached_OutLow;
   logic                   frog_reset_OutLow;
   logic                   clear_OutLow;
   logic [2:0]             lives_OutBUS;
   logic [SCORE_WIDTH-1:0] score_OutBUS;
   logic                   gameover_Out;

   modport master (
      output start_InLow, frog_row_InBUS, obstacle_row_InBUS, frog_at_top_In,
      input  shiftselection_Out, collision_OutLow, nest_reached_OutLow,
             frog_reset_OutLow, clear_OutLow, lives_OutBUS, score_OutBUS,
             gameover_Out
   );

   modport slave (
      input  start_InLow, frog_row_InBUS, obstacle_row_InBUS, frog_at_top_In,
      output shiftselection_Out, collision_OutLow, nest_reached_OutLow,
             frog_reset_OutLow, clear_OutLow, lives_OutBUS, score_OutBUS,
             gameover_Out
   );

endinterface
`default_nettype wire

// File: rtl/sc_frog_event_ctrl_prescaler.sv
`default_nettype none
//==============================================================================
// Module   : sc_prescaler_tick
// Purpose  : Free-running counter 0..PERIOD-1 with synchronous clear and count
//            enable; tick_Out is high in the cycle the enabled counter sits at
//            its terminal count (the counter wraps to 0 on that edge).
// Ports    : SC_RegPOINTTYPE_CLOCK_50     clock
//            SC_RegPOINTTYPE_RESET_InHigh async active-high reset
//            clear_In                     sync clear (wins over enable)
//            enable_In                    count enable
//            tick_Out                     terminal-count indication
// Revision : 1.0 - initial release
//==============================================================================
module sc_prescaler_tick #(
   parameter int PERIOD = 4,
   parameter int WIDTH  = 3
) (
   input  wire logic SC_RegPOINTTYPE_CLOCK_50,
   input  wire logic SC_RegPOINTTYPE_RESET_InHigh,
   input  wire logic clear_In,
   input  wire logic enable_In,
   output logic      tick_Out
);

   logic [WIDTH-1:0] r_count;
   logic             w_atTerminal;

   assign w_atTerminal = (r_count == WIDTH'(PERIOD - 1));
   assign tick_Out     = enable_In & ~clear_In & w_atTerminal;

   always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
      if (SC_RegPOINTTYPE_RESET_InHigh) begin
         r_count <= '0;
      end else if (clear_In) begin
         r_count <= '0;
      end else if (enable_In) begin
         r_count <= w_atTerminal ? '0 : r_count + WIDTH'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/sc_frog_event_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : sc_frog_event_ctrl
// Purpose  : Game control stage ahead of the point-type row registers. Issues
//            the periodic obstacle shift command, the active-low collision /
//            nest-reached / frog-reset / clear strobes, and tracks lives/score.
// Ports    : SC_RegPOINTTYPE_CLOCK_50     system clock
//            SC_RegPOINTTYPE_RESET_InHigh async active-high reset
//            bus (slave)                  row read-back inputs, start request,
//                                         strobes, lives, score, gameover
// Revision : 1.0 - initial release
//==============================================================================
module sc_frog_event_ctrl
   import sc_frog_event_ctrl_pkg::*;
#(
   parameter int                   DATAWIDTH       = 8,
   parameter int                   SHIFT_PERIOD    = 25000000,
   parameter int                   PRESCALER_WIDTH = 25,
   parameter logic [1:0]           SHIFT_DIR       = SHIFT_LEFT,
   parameter int                   HOLD_CYCLES     = 50000000,
   parameter int                   LIVES_INIT      = 3,
   parameter logic [DATAWIDTH-1:0] NEST_MASK       = DATAWIDTH'(NEST_MASK_DEFAULT),
   parameter int                   SCORE_WIDTH     = 4
) (
   input  wire logic          SC_RegPOINTTYPE_CLOCK_50,
   input  wire logic          SC_RegPOINTTYPE_RESET_InHigh,
   sc_frog_event_ctrl_if.slave bus
);

   localparam int         HOLD_WIDTH = clog2Min1(HOLD_CYCLES);
   localparam logic [2:0] c_livesInit = 3'(LIVES_INIT);

   frogState_t             r_state, w_stateNext;
   logic [2:0]             r_lives, w_livesNext;
   logic [SCORE_WIDTH-1:0] r_score, w_scoreNext;
   logic [1:0]             r_shift, w_shiftNext;
   logic                   r_collisionLow, w_collisionLowNext;
   logic                   r_nestLow, w_nestLowNext;
   logic                   r_frogResetLow, w_frogResetLowNext;
   logic                   r_clearLow, w_clearLowNext;

   logic w_hit, w_nest, w_frozen;
   logic w_presClear, w_presEnable, w_presTick;
   logic w_holdTick;

   assign w_hit    = |(bus.frog_row_InBUS & bus.obstacle_row_InBUS);
   assign w_nest   = bus.frog_at_top_In & (|(bus.frog_row_InBUS & NEST_MASK));
   assign w_frozen = (r_state == ST_HIT) || (r_state == ST_WIN);

   // The prescaler only runs in RUN; holding it cleared elsewhere gives a
   // fresh shift cadence on every start and every return from a freeze.
   assign w_presClear  = (r_state != ST_RUN);
   assign w_presEnable = (r_state == ST_RUN) & ~w_hit & ~w_nest;

   sc_prescaler_tick #(
      .PERIOD (SHIFT_PERIOD),
      .WIDTH  (PRESCALER_WIDTH)
   ) u_shiftPrescaler (
      .SC_RegPOINTTYPE_CLOCK_50     (SC_RegPOINTTYPE_CLOCK_50),
      .SC_RegPOINTTYPE_RESET_InHigh (SC_RegPOINTTYPE_RESET_InHigh),
      .clear_In                     (w_presClear),
      .enable_In                    (w_presEnable),
      .tick_Out                     (w_presTick)
   );

   // Hold counter sits at 0 outside a freeze, so each freeze starts from 0.
   sc_prescaler_tick #(
      .PERIOD (HOLD_CYCLES),
      .WIDTH  (HOLD_WIDTH)
   ) u_holdCounter (
      .SC_RegPOINTTYPE_CLOCK_50     (SC_RegPOINTTYPE_CLOCK_50),
      .SC_RegPOINTTYPE_RESET_InHigh (SC_RegPOINTTYPE_RESET_InHigh),
      .clear_In                     (~w_frozen),
      .enable_In                    (w_frozen),
      .tick_Out                     (w_holdTick)
   );

   always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
      if (SC_RegPOINTTYPE_RESET_InHigh) begin
         r_state        <= ST_IDLE;
         r_lives        <= c_livesInit;
         r_score        <= '0;
         r_shift        <= SHIFT_NONE;
         r_collisionLow <= 1'b1;
         r_nestLow      <= 1'b1;
         r_frogResetLow <= 1'b1;
         r_clearLow     <= 1'b1;
      end else begin
         r_state        <= w_stateNext;
         r_lives        <= w_livesNext;
         r_score        <= w_scoreNext;
         r_shift        <= w_shiftNext;
         r_collisionLow <= w_collisionLowNext;
         r_nestLow      <= w_nestLowNext;
         r_frogResetLow <= w_frogResetLowNext;
         r_clearLow     <= w_clearLowNext;
      end
   end

   always_comb begin
      w_stateNext        = r_state;
      w_livesNext        = r_lives;
      w_scoreNext        = r_score;
      w_shiftNext        = SHIFT_NONE;
      w_collisionLowNext = 1'b1;
      w_nestLowNext      = 1'b1;
      w_frogResetLowNext = 1'b1;
      w_clearLowNext     = 1'b1;

      case (r_state)
         ST_IDLE, ST_GAMEOVER: begin
            if (!bus.start_InLow) begin
               w_clearLowNext = 1'b0;
               w_livesNext    = c_livesInit;
               w_scoreNext    = '0;
               w_stateNext    = ST_RUN;
            end
         end
         ST_RUN: begin
            // Priority: hit, then nest, then the shift tick.
            if (w_hit) begin
               w_collisionLowNext = 1'b0;
               if (r_lives <= 3'd1) begin
                  w_livesNext = 3'd0;
                  w_stateNext = ST_GAMEOVER;
               end else begin
                  w_livesNext = r_lives - 3'd1;
                  w_stateNext = ST_HIT;
               end
            end else if (w_nest) begin
               w_nestLowNext = 1'b0;
               if (r_score != '1) w_scoreNext = r_score + SCORE_WIDTH'(1);
               w_stateNext = ST_WIN;
            end else if (w_presTick) begin
               w_shiftNext = SHIFT_DIR;
            end
         end
         ST_HIT, ST_WIN: begin
            if (w_holdTick) begin
               w_frogResetLowNext = 1'b0;
               w_stateNext        = ST_RUN;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   assign bus.shiftselection_Out  = r_shift;
   assign bus.collision_OutLow    = r_collisionLow;
   assign bus.nest_reached_OutLow = r_nestLow;
   assign bus.frog_reset_OutLow   = r_frogResetLow;
   assign bus.clear_OutLow        = r_clearLow;
   assign bus.lives_OutBUS        = r_lives;
   assign bus.score_OutBUS        = r_score;
   assign bus.gameover_Out        = (r_state == ST_GAMEOVER);

endmodule
`default_nettype wire

// File: tb/tb_sc_frog_event_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_sc_frog_event_ctrl
// Purpose  : Directed self-checking bench for sc_frog_event_ctrl with
//            SHIFT_PERIOD=4, HOLD_CYCLES=3, LIVES_INIT=3, SHIFT_DIR=01.
// Ports    : none
// Revision : 1.0 - initial release
//==============================================================================
module tb_sc_frog_event_ctrl;

   logic clk;
   logic rst;
   int   nComp;
   int   nFail;

   sc_frog_event_ctrl_if #(.DATAWIDTH(8), .SCORE_WIDTH(4)) bus ();

   sc_frog_event_ctrl #(
      .DATAWIDTH       (8),
      .SHIFT_PERIOD    (4),
      .PRESCALER_WIDTH (3),
      .SHIFT_DIR       (2'b01),
      .HOLD_CYCLES     (3),
      .LIVES_INIT      (3),
      .NEST_MASK       (8'b10101010),
      .SCORE_WIDTH     (4)
   ) dut (
      .SC_RegPOINTTYPE_CLOCK_50     (clk),
      .SC_RegPOINTTYPE_RESET_InHigh (rst),
      .bus                          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nComp++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full output vector check: shift, strobes (col, nest, frst, clr), lives, score, gameover.
   task automatic chkAll(input string tag, input logic [1:0] sh, input logic col,
                         input logic nst, input logic frs, input logic clr,
                         input logic [2:0] lv, input logic [3:0] sc, input logic go);
      chk({tag, ".shift"}, 32'(bus.shiftselection_Out), 32'(sh));
      chk({tag, ".coll"},  32'(bus.collision_OutLow), 32'(col));
      chk({tag, ".nest"},  32'(bus.nest_reached_OutLow), 32'(nst));
      chk({tag, ".frst"},  32'(bus.frog_reset_OutLow), 32'(frs));
      chk({tag, ".clr"},   32'(bus.clear_OutLow), 32'(clr));
      chk({tag, ".lives"}, 32'(bus.lives_OutBUS), 32'(lv));
      chk({tag, ".score"}, 32'(bus.score_OutBUS), 32'(sc));
      chk({tag, ".go"},    32'(bus.gameover_Out), 32'(go));
   endtask

   initial begin
      nComp = 0;
      nFail = 0;
      rst = 1'b1;
      bus.start_InLow        = 1'b1;
      bus.frog_row_InBUS     = 8'h01;
      bus.obstacle_row_InBUS = 8'h00;
      bus.frog_at_top_In     = 1'b0;
      step();
      step();
      chkAll("reset", 2'b00, 1, 1, 1, 1, 3'd3, 4'd0, 0);
      rst = 1'b0;
      step();
      chkAll("idle", 2'b00, 1, 1, 1, 1, 3'd3, 4'd0, 0);

      // Start: one-cycle clear, then a shift every 4th cycle.
      bus.start_InLow = 1'b0;
      step();
      chkAll("start", 2'b00, 1, 1, 1, 0, 3'd3, 4'd0, 0);
      bus.start_InLow = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         chkAll("cadence", (i % 4 == 0) ? 2'b01 : 2'b00, 1, 1, 1, 1, 3'd3, 4'd0, 0);
      end

      // First hit; obstacle stays during the freeze and must be ignored.
      bus.obstacle_row_InBUS = 8'h01;
      step();
      chkAll("hit1", 2'b00, 0, 1, 1, 1, 3'd2, 4'd0, 0);
      step();
      chkAll("hold1a", 2'b00, 1, 1, 1, 1, 3'd2, 4'd0, 0);
      step();
      chkAll("hold1b", 2'b00, 1, 1, 1, 1, 3'd2, 4'd0, 0);
      bus.obstacle_row_InBUS = 8'h00;
      step();
      chkAll("frst1", 2'b00, 1, 1, 0, 1, 3'd2, 4'd0, 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chkAll("recad", (i == 4) ? 2'b01 : 2'b00, 1, 1, 1, 1, 3'd2, 4'd0, 0);
      end

      // Second hit, then a third immediately after the freeze -> game over.
      bus.obstacle_row_InBUS = 8'h01;
      step();
      chkAll("hit2", 2'b00, 0, 1, 1, 1, 3'd1, 4'd0, 0);
      bus.obstacle_row_InBUS = 8'h00;
      step();
      step();
      step();
      chkAll("frst2", 2'b00, 1, 1, 0, 1, 3'd1, 4'd0, 0);
      bus.obstacle_row_InBUS = 8'h01;
      step();
      chkAll("hit3", 2'b00, 0, 1, 1, 1, 3'd0, 4'd0, 1);
      bus.obstacle_row_InBUS = 8'h00;
      for (int i = 0; i < 6; i++) begin
         step();
         chkAll("gameover", 2'b00, 1, 1, 1, 1, 3'd0, 4'd0, 1);
      end
      bus.start_InLow = 1'b0;
      step();
      chkAll("restart", 2'b00, 1, 1, 1, 0, 3'd3, 4'd0, 0);
      bus.start_InLow = 1'b1;

      // Nest in a nest column.
      bus.frog_at_top_In = 1'b1;
      bus.frog_row_InBUS = 8'h02;
      step();
      chkAll("nest1", 2'b00, 1, 0, 1, 1, 3'd3, 4'd1, 0);
      bus.frog_at_top_In = 1'b0;
      bus.frog_row_InBUS = 8'h01;
      step();
      step();
      chkAll("win.hold", 2'b00, 1, 1, 1, 1, 3'd3, 4'd1, 0);
      step();
      chkAll("frstW", 2'b00, 1, 1, 0, 1, 3'd3, 4'd1, 0);

      // Top row but not a nest column: no event; prescaler walks to 3.
      bus.frog_at_top_In = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chkAll("nonest", 2'b00, 1, 1, 1, 1, 3'd3, 4'd1, 0);
      end

      // Hit + nest + terminal count together: collision only.
      bus.frog_row_InBUS     = 8'h02;
      bus.obstacle_row_InBUS = 8'h02;
      step();
      chkAll("combo", 2'b00, 0, 1, 1, 1, 3'd2, 4'd1, 0);
      bus.frog_row_InBUS     = 8'h01;
      bus.obstacle_row_InBUS = 8'h00;
      bus.frog_at_top_In     = 1'b0;
      step();
      step();
      step();
      chkAll("frstC", 2'b00, 1, 1, 0, 1, 3'd2, 4'd1, 0);

      // Drive score up to 15, then one more nest saturates.
      for (int k = 2; k <= 16; k++) begin
         bus.frog_at_top_In = 1'b1;
         bus.frog_row_InBUS = 8'h80;
         step();
         chk("satNest.pulse", 32'(bus.nest_reached_OutLow), 32'd0);
         chk("satNest.score", 32'(bus.score_OutBUS), (k > 15) ? 32'd15 : 32'(k));
         bus.frog_at_top_In = 1'b0;
         bus.frog_row_InBUS = 8'h01;
         step();
         step();
         step();
         chk("satNest.frst", 32'(bus.frog_reset_OutLow), 32'd0);
      end

      // Reset right after a collision edge cancels the strobe at once.
      bus.obstacle_row_InBUS = 8'h01;
      step();
      chkAll("hit4", 2'b00, 0, 1, 1, 1, 3'd1, 4'd15, 0);
      rst = 1'b1;
      #1;
      chkAll("midreset", 2'b00, 1, 1, 1, 1, 3'd3, 4'd0, 0);
      bus.obstacle_row_InBUS = 8'h00;
      step();
      chkAll("held", 2'b00, 1, 1, 1, 1, 3'd3, 4'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
      $finish;
   end

endmodule
`default_nettype wire
